csr_arbiter: RTL and testbench
==============================

// Module: csr_arbiter
// PURPOSE
// Shares the single 5-bit-address/8-bit-data CSR register bus between the I2C slave
// (port I, cannot stall) and two on-chip requesters (ports 0/1, req/gnt/ack handshake).
// Port I has absolute priority on write strobes. Its read data comes from a shadow register
// refreshed from the bus, so secondary accesses never corrupt an I2C read.
// Sits between i2c_slave and the CSR register file.
// PARAMETERS
// ADDR_W  5  CSR address width
// DATA_W  8  CSR data width
// PORTS
// clk       in   1       system clock
// rst       in   1       sync reset, active-high
// i2c_a     in   ADDR_W  I2C slave address (index pointer)
// i2c_we    in   1       I2C single-cycle write strobe
// i2c_do    in   DATA_W  I2C write data
// i2c_di    out  DATA_W  I2C read data (shadow register)
// req[1:0]  in   2       secondary access request, held until gnt
// we[1:0]   in   2       secondary write (1) / read (0), valid with req
// a0,a1     in   ADDR_W  secondary addresses
// wd0,wd1   in   DATA_W  secondary write data
// gnt[1:0]  out  2       combinational grant; access completes in this cycle
// ack[1:0]  out  2       registered pulse, cycle after gnt
// rd0,rd1   out  DATA_W  registered read data, valid with ack
// csr_a     out  ADDR_W  bus address
// csr_we    out  1       bus write strobe
// csr_do    out  DATA_W  bus write data
// csr_di    in   DATA_W  bus read data (combinational from register file)
// BEHAVIOUR
// - Reset: gnt=0, ack=0, rd0=rd1=0, i2c_di=0, holdoff=0, rr_last=1 (port 0 preferred first).
// - Grant, same cycle: gnt[n]=req[n] & ~i2c_we & ~holdoff & RR win. At most one gnt bit is set.
// - RR: both requesting -> grant the port != rr_last. Single requester wins.
//   rr_last <= granted index on every grant.
// - holdoff <= |gnt. A grant therefore forces the following cycle to be I2C-owned, which
//   refreshes the shadow. Back-to-back grants are impossible.
// - Bus mux: granted port drives csr_a/csr_do, csr_we=we[n]. Otherwise I2C drives the bus,
//   csr_we=i2c_we.
// - i2c_we=1 overrides everything: bus goes to I2C and no grant is issued that cycle.
//   Pending reqs stay pending.
// - Shadow: i2c_di <= csr_di on every cycle with gnt==0. It holds during a secondary-owned
//   cycle. The I2C index only changes once per byte (many clk), so the shadow is always
//   current when the slave samples it.
// - Completion: on gnt[n], rd_n <= csr_di (read) or holds (write), and ack[n] <= 1 for one cycle.
// - Requester may drop or change req the cycle after gnt; re-request is honoured at the
//   earliest one cycle later.
// - Worst-case wait for a held req: 4 cycles (i2c_we + holdoff + other port + holdoff).
// - Reset mid-access: a pending ack is discarded. Grant is combinational, so no partial
//   write exists.
// - req with X address while gnt=0 must not affect the bus.
// CONFIGURATION
// CSR_ARB_STATS_EN defined: adds output stall_cnt[7:0]. It is a saturating count (stops at
//   255) of cycles where |req & ~|gnt, and it clears on rst.
// CSR_ARB_STATS_EN undefined: the port and counter are absent. Arbitration is identical.
// STRUCTURE
// - csr_pkg: CSR_ADDR_W=5, CSR_DATA_W=8 constants, typedef csr_addr_t, csr_data_t, port_idx_t (1 bit).
// - Sub-module csr_arb_rr: 2-way round-robin picker (req, rr_last -> onehot win).
//   All else is inline.
// TESTING
// - Reset: assert rst 2 cycles -> gnt=0, ack=0, i2c_di=0, csr_a=i2c_a.
// - Single read: regfile[0x07]=0x5A, req0 read a0=0x07 -> gnt0 same cycle, ack0+rd0=0x5A next cycle.
// - Contention: req0,req1 held 6 cycles -> grants alternate 0,gap,1,gap,0.
//   A gap cycle has csr_a=i2c_a.
// - I2C priority: i2c_we=1 (a=0x03,d=0xC3) with req1 write (a=0x03,d=0x11) -> regfile[0x03]=0xC3,
//   gnt1 deferred, next eligible cycle writes 0x11.
// - Shadow hold: i2c_a=0x02 (reg=0x22), req0 reads 0x09 (0x99) -> i2c_di stays 0x22 throughout.
// - Reset mid-op: rst asserted the cycle gnt1 fires -> ack1 never pulses. With CSR_ARB_STATS_EN,
//   a 300-cycle starved req gives stall_cnt=255 and rst gives 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR bus widths and types for the arbiter slice.
// Imported by the interface, the round-robin picker and the top.
package csr_pkg;

  localparam int CSR_ADDR_W = 5;
  localparam int CSR_DATA_W = 8;

  typedef logic [CSR_ADDR_W-1:0] csr_addr_t;
  typedef logic [CSR_DATA_W-1:0] csr_data_t;
  typedef logic                  port_idx_t;

endpackage

// File: rtl/csr_arbiter_if.sv
// CSR arbiter signal bundle: I2C slave side, two requesters, CSR bus.
// stall_cnt exists only when CSR_ARB_STATS_EN is defined.
interface csr_arbiter_if
  import csr_pkg::*;
#(
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int DATA_W = CSR_DATA_W
);

  logic [ADDR_W-1:0] i2c_a;
  logic              i2c_we;
  logic [DATA_W-1:0] i2c_do;
  logic [DATA_W-1:0] i2c_di;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  logic [ADDR_W-1:0] csr_a;
  logic              csr_we;
  logic [DATA_W-1:0] csr_do;
  logic [DATA_W-1:0] csr_di;

`ifdef CSR_ARB_STATS_EN
  logic [7:0]        stall_cnt;
`endif

  modport slave (
    input  i2c_a, i2c_we, i2c_do,
    input  req, we, a0, a1, wd0, wd1,
    input  csr_di,
    output i2c_di, gnt, ack, rd0, rd1,
`ifdef CSR_ARB_STATS_EN
    output stall_cnt,
`endif
    output csr_a, csr_we, csr_do
  );

  modport master (
    output i2c_a, i2c_we, i2c_do,
    output req, we, a0, a1, wd0, wd1,
    output csr_di,
    input  i2c_di, gnt, ack, rd0, rd1,
`ifdef CSR_ARB_STATS_EN
    input  stall_cnt,
`endif
    input  csr_a, csr_we, csr_do
  );

endinterface

// File: rtl/csr_arb_rr.sv
// Two-way round-robin picker: one-hot winner from req and last grant.
// On contention the port that was not granted last wins.
module csr_arb_rr
  import csr_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  rr_last,
  output logic [1:0] win
);

  // Pick a single winner; ties go to the port other than rr_last.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = rr_last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/csr_arbiter.sv
// Shares the CSR bus between the I2C slave and two requesters.
// Optional stall counter enabled by defining CSR_ARB_STATS_EN.
module csr_arbiter
  import csr_pkg::*;
#(
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int DATA_W = CSR_DATA_W
)(
  input logic         clk,
  input logic         rst,
  csr_arbiter_if.slave bus
);

  logic              holdoff;
  port_idx_t         rr_last;
  logic [1:0]        win;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] shadow;
  logic [ADDR_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_do;
  logic              mux_we;

  csr_arb_rr u_rr (
    .req     (bus.req),
    .rr_last (rr_last),
    .win     (win)
  );

  // I2C writes and the post-grant holdoff cycle both block grants.
  assign gnt = win & {2{~bus.i2c_we & ~holdoff}};

  // Granted port owns the bus; otherwise the I2C slave does.
  always_comb begin
    mux_a  = bus.i2c_a;
    mux_do = bus.i2c_do;
    mux_we = bus.i2c_we;
    unique case (1'b1)
      gnt[0]: begin
        mux_a  = bus.a0;
        mux_do = bus.wd0;
        mux_we = bus.we[0];
      end
      gnt[1]: begin
        mux_a  = bus.a1;
        mux_do = bus.wd1;
        mux_we = bus.we[1];
      end
      default: ;
    endcase
  end

  // Arbitration state, completion pulses, read data and I2C shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff <= 1'b0;
      rr_last <= 1'b1;
      ack     <= 2'b00;
      rd0     <= '0;
      rd1     <= '0;
      shadow  <= '0;
    end else begin
      holdoff <= |gnt;
      ack     <= gnt;
      if (|gnt)
        rr_last <= gnt[1];
      else
        shadow  <= bus.csr_di;
      if (gnt[0] && !bus.we[0])
        rd0 <= bus.csr_di;
      if (gnt[1] && !bus.we[1])
        rd1 <= bus.csr_di;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.ack    = ack;
  assign bus.rd0    = rd0;
  assign bus.rd1    = rd1;
  assign bus.i2c_di = shadow;
  assign bus.csr_a  = mux_a;
  assign bus.csr_do = mux_do;
  assign bus.csr_we = mux_we;

`ifdef CSR_ARB_STATS_EN
  logic [7:0] stall_cnt;

  // Saturating count of cycles with a request waiting and no grant.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= 8'd0;
    else if ((|bus.req) && !(|gnt) && stall_cnt != 8'hFF)
      stall_cnt <= stall_cnt + 8'd1;
  end

  assign bus.stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter with a behavioural CSR register file.
// Covers reset, RR contention, I2C priority, shadow hold, reset mid-access.
module tb_csr_arbiter;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic init_rf;

  always #5 clk = ~clk;

  csr_arbiter_if bus ();

  csr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] regfile [32];

  assign bus.csr_di = regfile[bus.csr_a];

  // Register file: preload on init_rf, else accept bus writes.
  always @(posedge clk) begin
    if (init_rf) begin
      for (int i = 0; i < 32; i++)
        regfile[i] <= (i == 7) ? 8'h5A : 8'(i * 17);
    end else if (bus.csr_we) begin
      regfile[bus.csr_a] <= bus.csr_do;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g [6];
  logic [4:0] exp_a [6];

  initial begin
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_a = '{5'h10, 5'h04, 5'h11, 5'h04, 5'h10, 5'h04};

    rst        = 1'b1;
    init_rf    = 1'b1;
    bus.i2c_a  = 5'h04;
    bus.i2c_we = 1'b0;
    bus.i2c_do = 8'h00;
    bus.req    = 2'b00;
    bus.we     = 2'b00;
    bus.a0     = 5'h00;
    bus.a1     = 5'h00;
    bus.wd0    = 8'h00;
    bus.wd1    = 8'h00;

    step();
    step();
    init_rf = 1'b0;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_ack", bus.ack, 2'b00);
    chk("rst_i2c_di", bus.i2c_di, 8'h00);
    chk("rst_csr_a", bus.csr_a, 5'h04);
    chk("rst_rd0", bus.rd0, 8'h00);
    chk("rst_rd1", bus.rd1, 8'h00);
    rst = 1'b0;

    bus.req = 2'b11;
    bus.a0  = 5'h10;
    bus.a1  = 5'h11;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk($sformatf("cont_gnt%0d", c), bus.gnt, exp_g[c]);
      chk($sformatf("cont_a%0d", c), bus.csr_a, exp_a[c]);
      step();
      chk($sformatf("cont_ack%0d", c), bus.ack, exp_g[c]);
    end
    bus.req = 2'b00;
    chk("cont_rd0", bus.rd0, 8'h10);
    chk("cont_rd1", bus.rd1, 8'h21);

    bus.req = 2'b01;
    bus.a0  = 5'h07;
    #2;
    chk("rd_gnt", bus.gnt, 2'b01);
    chk("rd_csr_a", bus.csr_a, 5'h07);
    chk("rd_csr_we", bus.csr_we, 1'b0);
    step();
    bus.req = 2'b00;
    chk("rd_ack", bus.ack, 2'b01);
    chk("rd_rd0", bus.rd0, 8'h5A);
    step();
    chk("rd_ack_off", bus.ack, 2'b00);

    bus.i2c_a  = 5'h03;
    bus.i2c_we = 1'b1;
    bus.i2c_do = 8'hC3;
    bus.req    = 2'b10;
    bus.we     = 2'b10;
    bus.a1     = 5'h03;
    bus.wd1    = 8'h11;
    #2;
    chk("pri_gnt", bus.gnt, 2'b00);
    chk("pri_we", bus.csr_we, 1'b1);
    chk("pri_do", bus.csr_do, 8'hC3);
    step();
    chk("pri_reg_i2c", regfile[3], 8'hC3);
    bus.i2c_we = 1'b0;
    #2;
    chk("pri_gnt1", bus.gnt, 2'b10);
    chk("pri_do1", bus.csr_do, 8'h11);
    chk("pri_a1", bus.csr_a, 5'h03);
    step();
    bus.req = 2'b00;
    bus.we  = 2'b00;
    chk("pri_reg_p1", regfile[3], 8'h11);
    chk("pri_ack", bus.ack, 2'b10);

    bus.i2c_a = 5'h02;
    step();
    chk("sh_init", bus.i2c_di, 8'h22);
    bus.req = 2'b01;
    bus.a0  = 5'h09;
    #2;
    chk("sh_gnt", bus.gnt, 2'b01);
    chk("sh_csr_di", bus.csr_di, 8'h99);
    step();
    bus.req = 2'b00;
    chk("sh_hold", bus.i2c_di, 8'h22);
    chk("sh_rd0", bus.rd0, 8'h99);
    step();
    chk("sh_after", bus.i2c_di, 8'h22);

    bus.req = 2'b10;
    bus.a1  = 5'h09;
    #2;
    chk("mid_gnt", bus.gnt, 2'b10);
    rst = 1'b1;
    step();
    bus.req = 2'b00;
    chk("mid_ack", bus.ack, 2'b00);
    chk("mid_rd1", bus.rd1, 8'h00);
    rst = 1'b0;
    step();
    chk("mid_ack2", bus.ack, 2'b00);

    bus.i2c_a = 5'h06;
    bus.a0    = 'x;
    #2;
    chk("x_csr_a", bus.csr_a, 5'h06);
    chk("x_csr_we", bus.csr_we, 1'b0);
    bus.a0 = 5'h00;

`ifdef CSR_ARB_STATS_EN
    step();
    bus.i2c_we = 1'b1;
    bus.req    = 2'b10;
    repeat (300) step();
    chk("stat_sat", bus.stall_cnt, 8'hFF);
    rst = 1'b1;
    step();
    chk("stat_rst", bus.stall_cnt, 8'h00);
    rst        = 1'b0;
    bus.i2c_we = 1'b0;
    bus.req    = 2'b00;
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
